// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the spi_master_mc block.
//   spi_state_e : transfer FSM states (IDLE/SETUP/XFER/HOLD)
//   spi_cfg_t   : per-transfer configuration latched on accept
//   CPOL_BIT / CPHA_BIT : bit positions inside the 2-bit mode input
//   cs_idx_w()  : width of the chip-select index for a given NUM_CS
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_cfg_t;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  function automatic int cs_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCLK divider for spi_master_mc.
// A DIV_W-bit counter reloads with the latched divider and ticks once every
// H = div+1 clocks while a transfer is active. Ticks with edge_en set toggle
// SCLK; each such toggle is classified as leading (leaving the idle level)
// or trailing (returning to it). While idle, SCLK follows idle_pol so the
// line already sits at the right CPOL before the next accept.
//   clk, rst_n  : clock, async active-low reset
//   idle        : FSM is in IDLE (counter frozen, SCLK tracks idle_pol)
//   idle_pol    : live CPOL request from the bus side
//   load, div   : accept strobe and divider value to latch
//   cpol        : CPOL latched for the running transfer
//   edge_en     : the next tick is an SCLK edge (SETUP/XFER)
//   tick        : divider period boundary
//   lead, trail : edge strobes, valid in the cycle before SCLK changes
//   sclk        : registered serial clock
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idle,
  input  logic             idle_pol,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             cpol,
  input  logic             edge_en,
  output logic             tick,
  output logic             lead,
  output logic             trail,
  output logic             sclk
);

  logic [DIV_W-1:0] div_q, cnt_q;
  logic             sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      if (load) begin
        div_q <= div;
        cnt_q <= div;
      end else if (!idle) begin
        cnt_q <= (cnt_q == '0) ? div_q : cnt_q - 1'b1;
      end
      if (idle)                sclk_q <= idle_pol;
      else if (tick && edge_en) sclk_q <= ~sclk_q;
    end
  end

  assign tick  = !idle && (cnt_q == '0);
  assign lead  = tick && edge_en && (sclk_q == cpol);
  assign trail = tick && edge_en && (sclk_q != cpol);
  assign sclk  = sclk_q;

endmodule

// File: rtl/spi_master_mc.sv
// spi_master_mc: parametrised SPI master with valid/ready request side.
// Each accepted word runs SETUP (H clocks, CS low, SCLK at CPOL), XFER
// (2*WIDTH SCLK edges, one per H clocks) and HOLD (2*H clocks), then CS
// rises and o_RX_DATA is loaded with a one-cycle o_rx_valid pulse.
// Optional build macro: SPI_LSB_FIRST_EN adds i_lsb_first (LSB-first TX/RX).
// Ports:
//   i_clk, i_rst            : clock, async active-low reset
//   i_mode[1:0]             : {CPOL,CPHA}, sampled on accept
//   i_div                   : SCLK half period minus one, sampled on accept
//   i_cs_sel                : slave index; out-of-range selects no slave
//   i_valid/o_ready/i_PDATA : transmit request handshake and word
//   o_RX_DATA, o_rx_valid   : last received word and its update pulse
//   o_busy                  : transfer in progress
//   o_sclk, o_mosi, i_miso  : SPI pins
//   o_cs_n                  : one-hot active-low chip selects
module spi_master_mc
  import spi_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CS = 4,
  parameter  int DIV_W  = 8,
  localparam int CS_W   = cs_idx_w(NUM_CS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_mode,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [CS_W-1:0]   i_cs_sel,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_PDATA,
`ifdef SPI_LSB_FIRST_EN
  input  logic              i_lsb_first,
`endif
  output logic [WIDTH-1:0]  o_RX_DATA,
  output logic              o_rx_valid,
  output logic              o_busy,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic [NUM_CS-1:0] o_cs_n
);

  // cnt_q counts divider ticks since accept: ticks 1..2W are SCLK edges,
  // ticks 2W+1 and 2W+2 are the HOLD tail.
  localparam int CNT_W = $clog2(2*WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_EDGE  = CNT_W'(2*WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(2*WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(2*WIDTH - 2);

  spi_state_e       state_q, state_d;
  spi_cfg_t         cfg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CS_W-1:0]  cs_sel_q;
  logic [WIDTH-1:0] tx_q, rx_q, rx_data_q;
  logic             rx_valid_q;
  logic             accept, done, lsb_in;
  logic             tick, lead, trail, edge_en, shift_en, sample_en;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = i_lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  assign o_ready = (state_q == IDLE);
  assign o_busy  = !o_ready;
  assign accept  = i_valid && o_ready;
  assign edge_en = (state_q == SETUP) || (state_q == XFER);

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .idle     (o_ready),
    .idle_pol (i_mode[CPOL_BIT]),
    .load     (accept),
    .div      (i_div),
    .cpol     (cfg_q.cpol),
    .edge_en  (edge_en),
    .tick     (tick),
    .lead     (lead),
    .trail    (trail),
    .sclk     (o_sclk)
  );

  // SETUP already presents the first bit, so the first launch edge of the
  // word (CPHA=1: edge 1) and the edge after the last capture (CPHA=0:
  // edge 2W) must not shift. cnt_q is edge number minus one here.
  assign shift_en  = (cfg_q.cpha ? lead : trail) && (cnt_q != '0) && (cnt_q <= LAST_SHIFT);
  assign sample_en = cfg_q.cpha ? trail : lead;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (tick) state_d = XFER;
      XFER:  if (tick && cnt_q == LAST_EDGE) state_d = HOLD;
      HOLD:  if (tick && cnt_q == LAST_TICK) begin
               state_d = IDLE;
               done    = 1'b1;
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q      <= '0;
      cfg_q      <= '0;
      cs_sel_q   <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= done;
      if (accept) begin
        cnt_q    <= '0;
        cfg_q    <= '{cpol: i_mode[CPOL_BIT], cpha: i_mode[CPHA_BIT], lsb_first: lsb_in};
        cs_sel_q <= i_cs_sel;
        tx_q     <= i_PDATA;
        rx_q     <= '0;
      end else begin
        if (tick) cnt_q <= cnt_q + 1'b1;
        if (shift_en)
          tx_q <= cfg_q.lsb_first ? {1'b0, tx_q[WIDTH-1:1]} : {tx_q[WIDTH-2:0], 1'b0};
        if (sample_en)
          rx_q <= cfg_q.lsb_first ? {i_miso, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], i_miso};
      end
      if (done) rx_data_q <= rx_q;
    end
  end

  assign o_mosi     = o_busy && (cfg_q.lsb_first ? tx_q[0] : tx_q[WIDTH-1]);
  assign o_RX_DATA  = rx_data_q;
  assign o_rx_valid = rx_valid_q;

  // Indices >= NUM_CS never match, so an out-of-range select drives no CS.
  for (genvar g = 0; g < NUM_CS; g++) begin : g_cs
    assign o_cs_n[g] = !(o_busy && (cs_sel_q == CS_W'(g)));
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: directed, table-driven bench for spi_master_mc.
// A negedge monitor records SCLK edge cycles, MOSI at leading edges, rx
// pulses and CS gaps; a second instance with NUM_CS=5 exercises an
// out-of-range chip select (index 5).
module tb_spi_master_mc;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] div;
    logic [2:0] cs;
    logic [7:0] tx;
    logic       lb;
    logic       lsb;
    logic [7:0] pat;
    logic [7:0] exp_rx;
    logic [3:0] exp_cs;
    logic       alt;
  } vec_t;

  logic       i_clk = 1'b0, i_rst = 1'b0;
  logic [1:0] i_mode = '0;
  logic [7:0] i_div = '0;
  logic [2:0] cs_sel = '0;
  logic       i_valid = 1'b0;
  logic [7:0] i_PDATA = '0;
  logic       i_lsb_first = 1'b0;
  logic       i_miso;
  logic       o_ready, o_rx_valid, o_busy, o_sclk, o_mosi;
  logic [7:0] o_RX_DATA;
  logic [3:0] o_cs_n;
  logic       o_ready2, o_rx_valid2, o_busy2, o_sclk2, o_mosi2;
  logic [7:0] o_RX_DATA2;
  logic [4:0] o_cs_n2;

  always #5 i_clk = ~i_clk;

  spi_master_mc #(.WIDTH(8), .NUM_CS(4), .DIV_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_div(i_div),
    .i_cs_sel(cs_sel[1:0]), .i_valid(i_valid), .o_ready(o_ready),
    .i_PDATA(i_PDATA),
`ifdef SPI_LSB_FIRST_EN
    .i_lsb_first(i_lsb_first),
`endif
    .o_RX_DATA(o_RX_DATA), .o_rx_valid(o_rx_valid), .o_busy(o_busy),
    .o_sclk(o_sclk), .o_mosi(o_mosi), .i_miso(i_miso), .o_cs_n(o_cs_n)
  );

  spi_master_mc #(.WIDTH(8), .NUM_CS(5), .DIV_W(8)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_div(i_div),
    .i_cs_sel(cs_sel), .i_valid(i_valid), .o_ready(o_ready2),
    .i_PDATA(i_PDATA),
`ifdef SPI_LSB_FIRST_EN
    .i_lsb_first(i_lsb_first),
`endif
    .o_RX_DATA(o_RX_DATA2), .o_rx_valid(o_rx_valid2), .o_busy(o_busy2),
    .o_sclk(o_sclk2), .o_mosi(o_mosi2), .i_miso(i_miso), .o_cs_n(o_cs_n2)
  );

  // stimulus-owned monitor controls
  logic       mon_clr = 1'b0, cur_cpol = 1'b0, cur_lb = 1'b0;
  logic [7:0] cur_pat = '0;
  // monitor-owned observations
  int         cyc = 0, t_acc = 0, rxv_cyc = 0, n_edges = 0, n_mosi = 0, n_rxv = 0, n_rxv2 = 0;
  int         pat_idx = 0, hi_run = 0, gap = 0;
  int         edge_cyc[32];
  logic       low_seen = 1'b0, cs2_all = 1'b1, sclk_prev = 1'b0;
  logic [7:0] mosi_act = '0;
  logic [3:0] cs_busy = '1;
  logic [7:0] rx_words[$];
  int         n_chk = 0, n_err = 0;

  assign i_miso = cur_lb ? o_mosi : ((pat_idx < 8) ? cur_pat[7 - pat_idx] : 1'b0);

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (mon_clr) begin
      n_edges = 0; n_mosi = 0; n_rxv = 0; n_rxv2 = 0; pat_idx = 0;
      hi_run = 0; gap = 0; low_seen = 1'b0; cs2_all = 1'b1;
      mosi_act = '0; cs_busy = '1; rx_words.delete();
    end else begin
      if (i_valid && o_ready) t_acc = cyc;
      if (o_sclk != sclk_prev) begin
        if (n_edges < 32) edge_cyc[n_edges] = cyc;
        n_edges++;
        if (sclk_prev == cur_cpol) begin
          if (n_mosi < 8) mosi_act[7 - n_mosi] = o_mosi;
          n_mosi++;
        end else begin
          pat_idx++;
        end
      end
      if (o_rx_valid) begin n_rxv++; rxv_cyc = cyc; rx_words.push_back(o_RX_DATA); end
      if (o_rx_valid2) n_rxv2++;
      cs2_all = cs2_all & (&o_cs_n2);
      if (&o_cs_n) hi_run++;
      else begin
        if (low_seen && hi_run > 0) gap = hi_run;
        hi_run = 0; low_seen = 1'b1;
      end
      if (o_busy) cs_busy = o_cs_n;
    end
    sclk_prev = o_sclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge i_clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic setup_inputs(input vec_t v);
    cur_cpol = v.mode[1]; cur_lb = v.lb; cur_pat = v.pat;
    @(posedge i_clk); #1;
    i_mode = v.mode; i_div = v.div; cs_sel = v.cs; i_PDATA = v.tx; i_lsb_first = v.lsb;
    repeat (2) @(posedge i_clk);
    #1;
    clear_mon();
  endtask

  task automatic wait_rx(input int n, input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(posedge i_clk);
      if (n_rxv >= n) break;
    end
    if (k == 3000) chk({name, "_timeout"}, 32'(n_rxv), 32'(n));
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic run(input vec_t v, input string name);
    int h;
    logic [7:0] exp_m;
    setup_inputs(v);
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    // busy-time changes must be ignored
    i_PDATA = ~v.tx; i_div = v.div + 8'd5; cs_sel = v.cs ^ 3'd2; i_lsb_first = ~v.lsb;
    wait_rx(1, name);
    h = int'(v.div) + 1;
    for (int i = 0; i < 8; i++) exp_m[7 - i] = v.lsb ? v.tx[i] : v.tx[7 - i];
    chk({name, "_rx_data"}, (rx_words.size() > 0) ? 32'(rx_words[0]) : 'x, 32'(v.exp_rx));
    chk({name, "_rx_pulses"}, 32'(n_rxv), 32'd1);
    chk({name, "_rx_latency"}, 32'(rxv_cyc - t_acc), 32'(1 + 18 * h));
    chk({name, "_cs_n"}, 32'(cs_busy), 32'(v.exp_cs));
    chk({name, "_first_edge"}, 32'(edge_cyc[0] - t_acc), 32'(1 + h));
    chk({name, "_edge_span"}, 32'(edge_cyc[15] - edge_cyc[0]), 32'(15 * h));
    chk({name, "_edge_cnt"}, 32'(n_edges), 32'd16);
    chk({name, "_mosi"}, 32'(mosi_act), 32'(exp_m));
    chk({name, "_idle_sclk"}, 32'(o_sclk), 32'(v.mode[1]));
    if (v.alt) begin
      chk({name, "_oor_cs_n"}, 32'(cs2_all), 32'd1);
      chk({name, "_oor_rx_pulses"}, 32'(n_rxv2), 32'd1);
    end
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    vecs[0] = '{2'd0, 8'd0, 3'd0, 8'hA5, 1'b0, 1'b0, 8'h3C, 8'h3C, 4'b1110, 1'b0};
    vecs[1] = '{2'd0, 8'd3, 3'd1, 8'hDB, 1'b1, 1'b0, 8'h00, 8'hDB, 4'b1101, 1'b0};
    vecs[2] = '{2'd1, 8'd3, 3'd1, 8'hDB, 1'b1, 1'b0, 8'h00, 8'hDB, 4'b1101, 1'b0};
    vecs[3] = '{2'd2, 8'd3, 3'd1, 8'hDB, 1'b1, 1'b0, 8'h00, 8'hDB, 4'b1101, 1'b0};
    vecs[4] = '{2'd3, 8'd3, 3'd1, 8'hDB, 1'b1, 1'b0, 8'h00, 8'hDB, 4'b1101, 1'b0};
    vecs[5] = '{2'd2, 8'd1, 3'd3, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h5A, 4'b0111, 1'b0};
    // index 5: out of range for the NUM_CS=5 instance, slave 1 for the main one
    vecs[6] = '{2'd1, 8'd0, 3'd5, 8'hC3, 1'b1, 1'b0, 8'h00, 8'hC3, 4'b1101, 1'b1};

    // reset values
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_cs_n", 32'(o_cs_n), 32'hF);
    chk("rst_sclk", 32'(o_sclk), 32'd0);
    chk("rst_mosi", 32'(o_mosi), 32'd0);
    chk("rst_rx_data", 32'(o_RX_DATA), 32'd0);
    chk("rst_rx_valid", 32'(o_rx_valid), 32'd0);
    i_rst = 1'b1;

    for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("vec%0d", i));

    // back-to-back: valid held across the rx_valid cycle
    v = '{2'd0, 8'd0, 3'd0, 8'h8D, 1'b1, 1'b0, 8'h00, 8'h00, 4'b1110, 1'b0};
    setup_inputs(v);
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_PDATA = 8'hDF;
    for (int k = 0; k < 200; k++) begin
      @(negedge i_clk);
      if (o_ready) break;
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    wait_rx(2, "b2b");
    chk("b2b_pulses", 32'(n_rxv), 32'd2);
    chk("b2b_word0", (rx_words.size() > 0) ? 32'(rx_words[0]) : 'x, 32'h8D);
    chk("b2b_word1", (rx_words.size() > 1) ? 32'(rx_words[1]) : 'x, 32'hDF);
    chk("b2b_cs_gap", 32'(gap), 32'd1);

    // reset after the third SCLK edge
    v = '{2'd0, 8'd1, 3'd0, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00, 4'b1110, 1'b0};
    setup_inputs(v);
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge i_clk);
      if (n_edges >= 3) break;
    end
    chk("rst_mid_edges", 32'(n_edges), 32'd3);
    @(negedge i_clk); #2;
    i_rst = 1'b0;
    #1;
    chk("rst_mid_cs_n", 32'(o_cs_n), 32'hF);
    chk("rst_mid_busy", 32'(o_busy), 32'd0);
    chk("rst_mid_ready", 32'(o_ready), 32'd1);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    repeat (40) @(posedge i_clk);
    #1;
    chk("rst_mid_no_rx", 32'(n_rxv), 32'd0);
    v = '{2'd0, 8'd0, 3'd2, 8'h11, 1'b1, 1'b0, 8'h00, 8'h11, 4'b1011, 1'b0};
    run(v, "after_rst");

`ifdef SPI_LSB_FIRST_EN
    v = '{2'd0, 8'd0, 3'd0, 8'h01, 1'b1, 1'b1, 8'h00, 8'h01, 4'b1110, 1'b0};
    run(v, "lsb");
    chk("lsb_first_bit", 32'(mosi_act[7]), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
